// File: rtl/mdio_responder_if.sv
// MDIO pad, register-write notification and host read port of the MDIO responder.
interface mdio_responder_if;
    logic        mdc_i;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_t;
    logic        reg_wr_o;
    logic [4:0]  reg_addr_o;
    logic [15:0] reg_data_o;
    logic        frame_err_o;
    logic [4:0]  host_addr_i;
    logic [15:0] host_data_o;

    modport slave (
        input  mdc_i, mdio_i, host_addr_i,
        output mdio_o, mdio_t, reg_wr_o, reg_addr_o, reg_data_o, frame_err_o, host_data_o
    );
    modport master (
        output mdc_i, mdio_i, host_addr_i,
        input  mdio_o, mdio_t, reg_wr_o, reg_addr_o, reg_data_o, frame_err_o, host_data_o
    );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO on clk_i, decodes frames to PHY_ADDR,
// serves a 32x16 register file (regs 2/3 are the read-only PHY ID).
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622,
    parameter int unsigned PREAMBLE_MIN = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    mdio_responder_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_e;

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_MIN);

    logic [1:0]  mdc_sync_q, mdio_sync_q;
    logic        mdc_prev_q;
    logic        bit_evt, bit_in;

    state_e      state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        op_hi_q, op_hi_d;
    logic        is_read_q, is_read_d;
    logic [4:0]  phy_q, phy_d;
    logic        match_q, match_d;
    logic [4:0]  regad_q, regad_d;
    logic [15:0] shift_q, shift_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_t_q, mdio_t_d;
    logic        reg_wr_q, reg_wr_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_data_q, reg_data_d;
    logic        frame_err_q, frame_err_d;

    logic [15:0] regfile_q [32];
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [4:0]  regad_next;
    logic [15:0] wdata_next;

    function automatic logic [15:0] rd_val(input logic [4:0] a);
        if (a == 5'd2)      return PHY_ID1;
        else if (a == 5'd3) return PHY_ID2;
        else                return regfile_q[a];
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            mdc_prev_q  <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[0], bus.mdc_i};
            mdio_sync_q <= {mdio_sync_q[0], bus.mdio_i};
            mdc_prev_q  <= mdc_sync_q[1];
        end
    end

    assign bit_evt    = mdc_sync_q[1] & ~mdc_prev_q;
    assign bit_in     = mdio_sync_q[1];
    assign regad_next = {regad_q[3:0], bit_in};
    assign wdata_next = {shift_q[14:0], bit_in};

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        op_hi_d     = op_hi_q;
        is_read_d   = is_read_q;
        phy_d       = phy_q;
        match_d     = match_q;
        regad_d     = regad_q;
        shift_d     = shift_q;
        mdio_o_d    = mdio_o_q;
        mdio_t_d    = mdio_t_q;
        reg_wr_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        frame_err_d = 1'b0;
        rf_we       = 1'b0;
        rf_wdata    = wdata_next;
        if (bit_evt) begin
            case (state_q)
                S_IDLE: begin
                    if (bit_in) begin
                        if (pre_cnt_q < PRE_MAX) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q == PRE_MAX) begin
                        // Count cleared here so the next return to IDLE starts a fresh preamble.
                        pre_cnt_d = '0;
                        state_d   = S_ST1;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                S_ST1: begin
                    bit_cnt_d = '0;
                    if (bit_in) state_d = S_OP;
                    else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_OP: begin
                    if (bit_cnt_q == 4'd0) begin
                        op_hi_d   = bit_in;
                        bit_cnt_d = 4'd1;
                    end else if (op_hi_q != bit_in) begin
                        is_read_d = op_hi_q;
                        bit_cnt_d = '0;
                        state_d   = S_PHYAD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_PHYAD: begin
                    phy_d     = {phy_q[3:0], bit_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd4) begin
                        match_d   = ({phy_q[3:0], bit_in} == PHY_ADDR);
                        bit_cnt_d = '0;
                        state_d   = S_REGAD;
                    end
                end
                S_REGAD: begin
                    regad_d   = regad_next;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd4) begin
                        if (is_read_q && match_q) shift_d = rd_val(regad_next);
                        bit_cnt_d = '0;
                        state_d   = S_TA;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 4'd0) begin
                        if (is_read_q && match_q) begin
                            mdio_t_d = 1'b0;
                            mdio_o_d = 1'b0;
                        end
                        bit_cnt_d = 4'd1;
                    end else begin
                        if (is_read_q && match_q) begin
                            mdio_o_d = shift_q[15];
                            shift_d  = {shift_q[14:0], 1'b0};
                        end
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (is_read_q && match_q) begin
                        mdio_o_d = shift_q[15];
                        shift_d  = {shift_q[14:0], 1'b0};
                    end else begin
                        shift_d  = wdata_next;
                    end
                    if (bit_cnt_q == 4'd15) begin
                        // This edge is the master's D0 sample point, so release the bus now.
                        mdio_t_d = 1'b1;
                        mdio_o_d = 1'b1;
                        if (!is_read_q && match_q && regad_q != 5'd2 && regad_q != 5'd3) begin
                            rf_we      = 1'b1;
                            reg_wr_d   = 1'b1;
                            reg_addr_d = regad_q;
                            reg_data_d = wdata_next;
                        end
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            op_hi_q     <= 1'b0;
            is_read_q   <= 1'b0;
            phy_q       <= '0;
            match_q     <= 1'b0;
            regad_q     <= '0;
            shift_q     <= '0;
            mdio_o_q    <= 1'b1;
            mdio_t_q    <= 1'b1;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            op_hi_q     <= op_hi_d;
            is_read_q   <= is_read_d;
            phy_q       <= phy_d;
            match_q     <= match_d;
            regad_q     <= regad_d;
            shift_q     <= shift_d;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regfile_q[i] <= '0;
        end else if (rf_we) begin
            regfile_q[regad_q] <= rf_wdata;
        end
    end

    assign bus.mdio_o      = mdio_o_q;
    assign bus.mdio_t      = mdio_t_q;
    assign bus.reg_wr_o    = reg_wr_q;
    assign bus.reg_addr_o  = reg_addr_q;
    assign bus.reg_data_o  = reg_data_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.host_data_o = rd_val(bus.host_addr_i);
endmodule
